cache_ctrl_assoc: RTL and testbench
===================================

Name: cache_ctrl_assoc

Overview:
- Parametrised N-way set-associative cache controller FSM; the next generation of the direct-mapped controller.
- Sits between the CPU memory stage and WAYS instances of the cache array module, plus the four-banked main memory.
- Does single-cycle hit lookup across all ways and per-set MRU-based victim selection.
- On a miss: dirty-line writeback, pipelined line refill tracking the memory read latency, then completes the original access.

Parameters:
- TAG_W, 5, tag bits.
- INDEX_W, 8, set index bits.
- OFFSET_W, 3, byte offset bits; line holds WORDS = 2^(OFFSET_W-1) 16-bit words (default 4).
- WAYS, 2, associativity; legal values 1, 2, 4.
- MEM_RD_LAT, 2, cycles from accepted fm_rd to valid m_data_out.
- ADDR_W = TAG_W+INDEX_W+OFFSET_W; must equal 16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  16  CPU byte address
- data_in  in  16  CPU write data
- read  in  1  CPU read request
- write  in  1  CPU write request
- c_tag_out  in  WAYS*TAG_W  per-way tag, way w at [w*TAG_W +: TAG_W]
- c_data_out  in  WAYS*16  per-way read data
- c_hit, c_dirty, c_valid, c_err  in  WAYS each  per-way status
- m_data_out  in  16  memory read data
- m_stall  in  1  memory cannot accept a request this cycle
- m_busy  in  4  per-bank busy
- m_err  in  1  memory error
- fc_enable  out  WAYS  per-way cache enable
- fc_tag_in  out  TAG_W  tag to cache
- fc_index  out  INDEX_W  set index
- fc_offset  out  OFFSET_W  byte offset
- fc_data_in  out  16  cache write data
- fc_comp  out  1  compare mode
- fc_write  out  1  cache write
- fc_valid_in  out  1  valid bit written
- fm_addr  out  16  memory address
- fm_data_in  out  16  memory write data
- fm_wr  out  1  memory write
- fm_rd  out  1  memory read
- fs_data_out  out  16  read data to CPU
- fs_done  out  1  access complete, one-cycle pulse
- fs_stall  out  1  CPU must hold request
- fs_cachehit  out  1  completed access hit
- fs_err  out  1  error, qualified by fs_done

Behaviour:
Reset
- rst=1 at a clock edge: state IDLE, all MRU pointers 0, pending-return shift register cleared, error flag cleared.
- All outputs are 0 during and after reset until a request arrives.
- Reset mid-miss abandons the transfer; no further fm_rd/fm_wr; in-flight return data is ignored.

Request checks
- read&write together: fs_done=1, fs_err=1 same cycle, no cache or memory action.

IDLE (lookup)
- On read^write: fc_enable=all ones, fc_comp=1, fc_write=write, fc_data_in=data_in.
- Hit = OR over ways of c_hit&c_valid.
- On hit, same cycle: fs_done=1, fs_cachehit=1; fs_data_out = hitting way's data (reads); MRU[index] <= hitting way.
- On miss: latch addr, data, op; victim = lowest-index invalid way, else (MRU[index]+1) mod WAYS; fs_stall=1.
  - Go to WB if victim valid&dirty, else FILL.

WB
- Counter k = 0..WORDS-1. Victim way enabled with fc_comp=0, fc_write=0, fc_offset={k,1'b0}.
- fm_wr=1, fm_addr={victim tag, index, k, 1'b0}, fm_data_in=c_data_out[victim].
- k advances only on cycles with !m_stall. After the last accepted write, go to FILL.

FILL
- Issue counter i: fm_rd with fm_addr={req tag, index, i, 1'b0}, one per !m_stall cycle, until WORDS issued.
- Each accepted issue pushes a token into a MEM_RD_LAT-deep shift register.
- When a token emerges, write m_data_out into the victim way: fc_comp=0, fc_write=1, fc_valid_in=1, fc_tag_in=req tag, offset = return counter j.
- j increments per return. Issues and returns overlap.
- After return WORDS-1, go to COMPLETE.

COMPLETE
- Repeat the original access on the victim way with fc_comp=1; a write sets dirty.
- fs_done=1, fs_cachehit=0; MRU[index] <= victim. Go to IDLE.

Stall and errors
- fs_stall=1 in every non-IDLE state and in the IDLE miss cycle.
- Any c_err or m_err during a transaction sets the sticky error flag.
- fs_err = flag & fs_done; the flag clears on return to IDLE.
- WAYS=1 degenerates to direct-mapped behaviour; no MRU storage.

Optional Feature:
- CACHE_PERF_CNT_EN defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on IDLE hits; miss_cnt increments on IDLE miss detection.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and logic absent.

Decomposition:
- Package cache_ctrl_pkg holds: state enum (IDLE, WB, FILL, COMPLETE), WORDS derivation, way-index width function.
- Sub-module cache_victim_sel: per-set MRU storage plus victim/hit-way encode, parametrised on WAYS and INDEX_W.

Test Plan:
- 2-way: fill index 0x12 with tags 0x03 and 0x07, then read addr {0x07,0x12,3'b010} -> fs_done and fs_cachehit in the request cycle, data from way 1.
- Cold read miss, clean victim -> 4 fm_rd at offsets 0, 2, 4, 6; 4 fill writes with fc_valid_in=1; fs_done 1 cycle after the last return; fs_cachehit=0.
- Dirty victim -> 4 fm_wr with the victim tag address precede the first fm_rd; fm_data_in matches the cached words.
- MRU: access tags A, B at the same set, then C -> A evicted; a re-read of B hits.
- m_stall held 3 cycles during FILL -> fm_addr/fm_rd hold, no skipped or duplicated words; rst asserted mid-FILL -> next cycle IDLE, outputs 0.
- read=write=1 -> fs_done=1, fs_err=1 same cycle, no fm_rd/fm_wr.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared types and helpers for the set-associative cache
//               controller. It provides the controller state encoding, the
//               words-per-line derivation and the way-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

    // Controller states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WB       = 2'd1,
        ST_FILL     = 2'd2,
        ST_COMPLETE = 2'd3
    } state_e;

    // A line holds 16-bit words, so the byte offset minus one bit selects a word.
    function automatic int words_of(input int offset_w);
        return 1 << (offset_w - 1);
    endfunction

    // A one-way cache still needs a 1-bit index so that port widths stay legal.
    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : cache_victim_sel
// Description : Per-set MRU storage, hit-way encoder and victim selection.
//               The victim is the lowest-index invalid way. If every way is
//               valid, the victim is the way after the MRU way (mod WAYS).
//               A one-way build keeps no MRU storage.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               lookup_index      - set index being looked up
//               hit_vec/valid_vec - per-way qualified hit / valid
//               upd_we/index/way  - MRU update request
//               hit_way           - encoded lowest hitting way
//               victim_way        - replacement candidate for lookup_index
// Revision    : 1.0 - initial release
// ============================================================================
module cache_victim_sel
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 8,
    localparam int WIDX   = way_idx_w(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [WAYS-1:0]    hit_vec,
    input  logic [WAYS-1:0]    valid_vec,
    input  logic               upd_we,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [WIDX-1:0]    upd_way,
    output logic [WIDX-1:0]    hit_way,
    output logic [WIDX-1:0]    victim_way
);

    logic [WIDX-1:0] w_mru_rd;

    generate
        if (WAYS > 1) begin : g_mru
            logic [WIDX-1:0] mru_q [2**INDEX_W];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < 2**INDEX_W; s++) begin
                        mru_q[s] <= '0;
                    end
                end else if (upd_we) begin
                    mru_q[upd_index] <= upd_way;
                end
            end

            assign w_mru_rd = mru_q[lookup_index];
        end else begin : g_no_mru
            logic unused_mru_inputs;
            assign unused_mru_inputs = ^{clk, rst, lookup_index, upd_we, upd_index, upd_way};
            assign w_mru_rd          = '0;
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        // Descending scan so that the lowest set bit wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = w[WIDX-1:0];
            end
        end

        // WAYS is a power of two, so the WIDX-bit wrap gives the mod.
        victim_way = (WAYS > 1) ? (w_mru_rd + 1'b1) : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim_way = w[WIDX-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_assoc.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_assoc
// Description : N-way set-associative cache controller. It performs a
//               single-cycle hit lookup across all ways and MRU-based
//               replacement. A miss writes back a dirty victim, refills the
//               line through a pipelined read path, then repeats the access.
// Ports       : CPU side    addr, data_in, read, write -> fs_* status/data
//               Cache side  c_* per-way status/data in, fc_* controls out
//               Memory side m_* status/data in, fm_* requests out
// Options     : CACHE_PERF_CNT_EN adds saturating hit_cnt / miss_cnt outputs
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_assoc
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_W      = 5,
    parameter int INDEX_W    = 8,
    parameter int OFFSET_W   = 3,
    parameter int WAYS       = 2,
    parameter int MEM_RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           addr,
    input  logic [15:0]           data_in,
    input  logic                  read,
    input  logic                  write,
    input  logic [WAYS*TAG_W-1:0] c_tag_out,
    input  logic [WAYS*16-1:0]    c_data_out,
    input  logic [WAYS-1:0]       c_hit,
    input  logic [WAYS-1:0]       c_dirty,
    input  logic [WAYS-1:0]       c_valid,
    input  logic [WAYS-1:0]       c_err,
    input  logic [15:0]           m_data_out,
    input  logic                  m_stall,
    input  logic [3:0]            m_busy,
    input  logic                  m_err,
    output logic [WAYS-1:0]       fc_enable,
    output logic [TAG_W-1:0]      fc_tag_in,
    output logic [INDEX_W-1:0]    fc_index,
    output logic [OFFSET_W-1:0]   fc_offset,
    output logic [15:0]           fc_data_in,
    output logic                  fc_comp,
    output logic                  fc_write,
    output logic                  fc_valid_in,
    output logic [15:0]           fm_addr,
    output logic [15:0]           fm_data_in,
    output logic                  fm_wr,
    output logic                  fm_rd,
    output logic [15:0]           fs_data_out,
    output logic                  fs_done,
    output logic                  fs_stall,
    output logic                  fs_cachehit,
    output logic                  fs_err
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    localparam int WORDS  = words_of(OFFSET_W);
    localparam int WIDX   = way_idx_w(WAYS);
    localparam int CNT_W  = OFFSET_W - 1;
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;  // must be 16

    state_e                state_q, state_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [WIDX-1:0]       victim_q, victim_d;
    logic [TAG_W-1:0]      vtag_q, vtag_d;
    logic [CNT_W-1:0]      wb_cnt_q, wb_cnt_d;
    logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
    logic [OFFSET_W-1:0]   iss_cnt_q, iss_cnt_d;
    logic [MEM_RD_LAT-1:0] pend_q, pend_d;
    logic                  err_q, err_d;

    logic                  w_req, w_conflict, w_any_hit, w_err_now, w_issue, w_ret;
    logic [WAYS-1:0]       w_hit_vec, w_victim_oh;
    logic [WIDX-1:0]       w_hit_way, w_victim_way, w_mru_way;
    logic                  w_mru_we;
    logic [INDEX_W-1:0]    w_mru_idx;
    logic [15:0]           w_hit_data, w_vic_data;
    logic [TAG_W-1:0]      w_new_vtag;

    wire  [TAG_W-1:0]      w_cpu_tag = addr[ADDR_W-1 -: TAG_W];
    wire  [INDEX_W-1:0]    w_cpu_idx = addr[OFFSET_W +: INDEX_W];
    wire  [OFFSET_W-1:0]   w_cpu_off = addr[OFFSET_W-1:0];
    wire  [TAG_W-1:0]      w_req_tag = addr_q[ADDR_W-1 -: TAG_W];
    wire  [INDEX_W-1:0]    w_req_idx = addr_q[OFFSET_W +: INDEX_W];
    wire  [OFFSET_W-1:0]   w_req_off = addr_q[OFFSET_W-1:0];

    // Bank conflicts reach the controller through m_stall; per-bank busy is informational.
    logic unused_busy;
    assign unused_busy = ^m_busy;

    assign w_req      = read ^ write;
    assign w_conflict = read & write;
    assign w_hit_vec  = c_hit & c_valid;
    assign w_any_hit  = |w_hit_vec;
    assign w_err_now  = (|c_err) | m_err;
    assign w_ret      = pend_q[MEM_RD_LAT-1];

    cache_victim_sel #(
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W)
    ) u_victim_sel (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (w_cpu_idx),
        .hit_vec      (w_hit_vec),
        .valid_vec    (c_valid),
        .upd_we       (w_mru_we),
        .upd_index    (w_mru_idx),
        .upd_way      (w_mru_way),
        .hit_way      (w_hit_way),
        .victim_way   (w_victim_way)
    );

    // Per-way muxing with constant part-selects.
    always_comb begin
        w_hit_data  = '0;
        w_vic_data  = '0;
        w_new_vtag  = '0;
        w_victim_oh = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_way == w[WIDX-1:0])    w_hit_data = c_data_out[w*16 +: 16];
            if (victim_q == w[WIDX-1:0])     w_vic_data = c_data_out[w*16 +: 16];
            if (w_victim_way == w[WIDX-1:0]) w_new_vtag = c_tag_out[w*TAG_W +: TAG_W];
            w_victim_oh[w] = (victim_q == w[WIDX-1:0]);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        victim_d    = victim_q;
        vtag_d      = vtag_q;
        wb_cnt_d    = wb_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        iss_cnt_d   = iss_cnt_q;
        err_d       = err_q | w_err_now;
        w_issue     = 1'b0;
        w_mru_we    = 1'b0;
        w_mru_way   = victim_q;
        w_mru_idx   = w_req_idx;

        fc_enable   = '0;
        fc_tag_in   = '0;
        fc_index    = '0;
        fc_offset   = '0;
        fc_data_in  = '0;
        fc_comp     = 1'b0;
        fc_write    = 1'b0;
        fc_valid_in = 1'b0;
        fm_addr     = '0;
        fm_data_in  = '0;
        fm_wr       = 1'b0;
        fm_rd       = 1'b0;
        fs_data_out = '0;
        fs_done     = 1'b0;
        fs_stall    = 1'b0;
        fs_cachehit = 1'b0;
        fs_err      = 1'b0;

        // Outputs stay quiet while reset is held, whatever state is left over.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    err_d = 1'b0;
                    if (w_conflict) begin
                        fs_done = 1'b1;
                        fs_err  = 1'b1;
                    end else if (w_req) begin
                        fc_enable  = '1;
                        fc_comp    = 1'b1;
                        fc_write   = write;
                        fc_data_in = data_in;
                        fc_tag_in  = w_cpu_tag;
                        fc_index   = w_cpu_idx;
                        fc_offset  = w_cpu_off;
                        if (w_any_hit) begin
                            fs_done     = 1'b1;
                            fs_cachehit = 1'b1;
                            fs_err      = w_err_now;
                            if (read) fs_data_out = w_hit_data;
                            w_mru_we  = 1'b1;
                            w_mru_way = w_hit_way;
                            w_mru_idx = w_cpu_idx;
                        end else begin
                            fs_stall  = 1'b1;
                            addr_d    = addr;
                            wdata_d   = data_in;
                            wr_d      = write;
                            victim_d  = w_victim_way;
                            vtag_d    = w_new_vtag;
                            err_d     = w_err_now;
                            wb_cnt_d  = '0;
                            ret_cnt_d = '0;
                            iss_cnt_d = '0;
                            state_d   = (c_valid[w_victim_way] && c_dirty[w_victim_way])
                                        ? ST_WB : ST_FILL;
                        end
                    end
                end

                ST_WB: begin
                    fs_stall   = 1'b1;
                    fc_enable  = w_victim_oh;
                    fc_tag_in  = vtag_q;
                    fc_index   = w_req_idx;
                    fc_offset  = {wb_cnt_q, 1'b0};
                    fm_wr      = 1'b1;
                    fm_addr    = {vtag_q, w_req_idx, wb_cnt_q, 1'b0};
                    fm_data_in = w_vic_data;
                    if (!m_stall) begin
                        wb_cnt_d = wb_cnt_q + 1'b1;
                        if (wb_cnt_q == CNT_W'(WORDS - 1)) state_d = ST_FILL;
                    end
                end

                ST_FILL: begin
                    fs_stall = 1'b1;
                    // Issue side: one read per accepted cycle until the whole line is requested.
                    if (iss_cnt_q != OFFSET_W'(WORDS)) begin
                        fm_rd   = 1'b1;
                        fm_addr = {w_req_tag, w_req_idx, iss_cnt_q[CNT_W-1:0], 1'b0};
                        if (!m_stall) begin
                            w_issue   = 1'b1;
                            iss_cnt_d = iss_cnt_q + 1'b1;
                        end
                    end
                    // Return side: data arrives MEM_RD_LAT cycles after each accepted issue.
                    if (w_ret) begin
                        fc_enable   = w_victim_oh;
                        fc_write    = 1'b1;
                        fc_valid_in = 1'b1;
                        fc_tag_in   = w_req_tag;
                        fc_index    = w_req_idx;
                        fc_offset   = {ret_cnt_q, 1'b0};
                        fc_data_in  = m_data_out;
                        ret_cnt_d   = ret_cnt_q + 1'b1;
                        if (ret_cnt_q == CNT_W'(WORDS - 1)) state_d = ST_COMPLETE;
                    end
                end

                ST_COMPLETE: begin
                    fs_stall   = 1'b1;
                    fc_enable  = w_victim_oh;
                    fc_comp    = 1'b1;
                    fc_write   = wr_q;
                    fc_tag_in  = w_req_tag;
                    fc_index   = w_req_idx;
                    fc_offset  = w_req_off;
                    fc_data_in = wdata_q;
                    if (!wr_q) fs_data_out = w_vic_data;
                    fs_done    = 1'b1;
                    fs_err     = err_q | w_err_now;
                    w_mru_we   = 1'b1;
                    err_d      = 1'b0;
                    state_d    = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end

        pend_d[0] = w_issue;
        for (int p = 1; p < MEM_RD_LAT; p++) begin
            pend_d[p] = pend_q[p-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            victim_q  <= '0;
            vtag_q    <= '0;
            wb_cnt_q  <= '0;
            ret_cnt_q <= '0;
            iss_cnt_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            victim_q  <= victim_d;
            vtag_q    <= vtag_d;
            wb_cnt_q  <= wb_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_IDLE && w_req) begin
            if (w_any_hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_assoc
// Description : Directed self-checking bench for cache_ctrl_assoc (2-way,
//               default geometry). It models two cache arrays and a
//               pipelined memory whose word at word-address A reads as
//               16'h8000 | A until it is written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_assoc;

    localparam int TAG_W = 5;
    localparam int WAYS  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [15:0]           addr, data_in;
    logic                  read, write;
    logic [WAYS*TAG_W-1:0] c_tag_out;
    logic [WAYS*16-1:0]    c_data_out;
    logic [WAYS-1:0]       c_hit, c_dirty, c_valid, c_err;
    logic [15:0]           m_data_out;
    logic                  m_stall, m_err;
    logic [3:0]            m_busy;
    logic [WAYS-1:0]       fc_enable;
    logic [TAG_W-1:0]      fc_tag_in;
    logic [7:0]            fc_index;
    logic [2:0]            fc_offset;
    logic [15:0]           fc_data_in, fm_addr, fm_data_in, fs_data_out;
    logic                  fc_comp, fc_write, fc_valid_in, fm_wr, fm_rd;
    logic                  fs_done, fs_stall, fs_cachehit, fs_err;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0]           hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    cache_ctrl_assoc dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .read(read), .write(write),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_hit(c_hit), .c_dirty(c_dirty),
        .c_valid(c_valid), .c_err(c_err), .m_data_out(m_data_out), .m_stall(m_stall),
        .m_busy(m_busy), .m_err(m_err), .fc_enable(fc_enable), .fc_tag_in(fc_tag_in),
        .fc_index(fc_index), .fc_offset(fc_offset), .fc_data_in(fc_data_in),
        .fc_comp(fc_comp), .fc_write(fc_write), .fc_valid_in(fc_valid_in),
        .fm_addr(fm_addr), .fm_data_in(fm_data_in), .fm_wr(fm_wr), .fm_rd(fm_rd),
        .fs_data_out(fs_data_out), .fs_done(fs_done), .fs_stall(fs_stall),
        .fs_cachehit(fs_cachehit), .fs_err(fs_err)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // ---------------- cache array model ----------------
    logic [TAG_W-1:0] cm_tag   [WAYS][256];
    logic             cm_valid [WAYS][256];
    logic             cm_dirty [WAYS][256];
    logic [15:0]      cm_data  [WAYS][256][4];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            c_tag_out[w*TAG_W +: TAG_W] = cm_tag[w][fc_index];
            c_data_out[w*16 +: 16]      = cm_data[w][fc_index][fc_offset[2:1]];
            c_valid[w] = cm_valid[w][fc_index];
            c_dirty[w] = cm_dirty[w][fc_index];
            c_hit[w]   = fc_enable[w] && fc_comp && (cm_tag[w][fc_index] == fc_tag_in);
        end
    end

    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fc_enable[w] && fc_write) begin
                if (fc_comp) begin
                    if (cm_valid[w][fc_index] && cm_tag[w][fc_index] == fc_tag_in) begin
                        cm_data[w][fc_index][fc_offset[2:1]] <= fc_data_in;
                        cm_dirty[w][fc_index] <= 1'b1;
                    end
                end else begin
                    cm_data[w][fc_index][fc_offset[2:1]] <= fc_data_in;
                    cm_tag[w][fc_index]   <= fc_tag_in;
                    cm_valid[w][fc_index] <= fc_valid_in;
                    cm_dirty[w][fc_index] <= 1'b0;
                end
            end
        end
    end

    // ---------------- memory model + event log ----------------
    logic [15:0] mem [0:32767];
    logic [15:0] rd_p0, rd_p1;
    logic        ev_wr   [$];
    logic [15:0] ev_addr [$];
    logic [15:0] ev_data [$];
    int          fill_wr_cnt = 0;

    assign m_data_out = mem[rd_p1[15:1]];

    always @(posedge clk) begin
        rd_p1 <= rd_p0;
        rd_p0 <= 16'h0;
        if (fm_wr && !m_stall) begin
            mem[fm_addr[15:1]] <= fm_data_in;
            ev_wr.push_back(1'b1); ev_addr.push_back(fm_addr); ev_data.push_back(fm_data_in);
        end
        if (fm_rd && !m_stall) begin
            rd_p0 <= fm_addr;
            ev_wr.push_back(1'b0); ev_addr.push_back(fm_addr); ev_data.push_back(16'h0);
        end
        if (fc_write && !fc_comp && fc_valid_in && |fc_enable) fill_wr_cnt <= fill_wr_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] r_data;
    logic        r_hit, r_err;
    int          r_lat;

    task automatic wait_done();
        r_lat = 0;
        #1;
        while (fs_done !== 1'b1 && r_lat < 60) begin
            @(negedge clk); #1; r_lat++;
        end
        check_val("done_seen", 32'(fs_done), 32'd1);
        r_data = fs_data_out; r_hit = fs_cachehit; r_err = fs_err;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic access(input logic [15:0] a, input logic wr, input logic [15:0] d);
        @(negedge clk);
        addr = a; data_in = d; read = !wr; write = wr;
        wait_done();
    endtask

    int base, fbase;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h8000 | 16'(i);
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < 256; s++) begin
                cm_valid[w][s] = 1'b0; cm_dirty[w][s] = 1'b0; cm_tag[w][s] = '0;
                for (int k = 0; k < 4; k++) cm_data[w][s][k] = 16'h0;
            end
        rd_p0 = 16'h0; rd_p1 = 16'h0;
        rst = 1'b1; read = 1'b0; write = 1'b0; addr = 16'h0; data_in = 16'h0;
        m_stall = 1'b0; m_err = 1'b0; c_err = '0; m_busy = 4'h0;

        // Reset
        repeat (2) @(negedge clk);
        #1 check_val("rst_outs", {fs_done, fs_stall, fm_rd, fm_wr, fc_enable, fc_write, fc_comp}, 32'h0);
        @(negedge clk); rst = 1'b0;
        #1 check_val("idle_outs", {fs_done, fs_stall, fm_rd, fm_wr, fc_enable, fs_err}, 32'h0);
        check_val("idle_addr", {fm_addr, fs_data_out}, 32'h0);

        // Cold read miss, clean victim (tag 3, set 0x12)
        base = ev_addr.size(); fbase = fill_wr_cnt;
        access(16'h1892, 1'b0, 16'h0);
        check_val("cold_lat", r_lat, 7);
        check_val("cold_hit", 32'(r_hit), 32'd0);
        check_val("cold_data", 32'(r_data), 32'h8C49);
        check_val("cold_nrd", ev_addr.size() - base, 4);
        check_val("cold_rd0", {ev_wr[base], ev_addr[base]}, {1'b0, 16'h1890});
        check_val("cold_rd3", {ev_wr[base+3], ev_addr[base+3]}, {1'b0, 16'h1896});
        check_val("cold_fills", fill_wr_cnt - fbase, 4);

        // Second tag into the same set lands in way 1
        access(16'h3892, 1'b0, 16'h0);
        check_val("way1_lat", r_lat, 7);
        check_val("way1_data", 32'(r_data), 32'h9C49);

        // Hits in the request cycle
        access(16'h3892, 1'b0, 16'h0);
        check_val("hit1", {r_lat[7:0], 7'h0, r_hit, r_data}, {8'd0, 7'h0, 1'b1, 16'h9C49});
        access(16'h1892, 1'b0, 16'h0);
        check_val("hit0", {r_lat[7:0], 7'h0, r_hit, r_data}, {8'd0, 7'h0, 1'b1, 16'h8C49});

        // Write hit dirties way 0, then make way 1 the MRU
        access(16'h1894, 1'b1, 16'hBEEF);
        check_val("wr_hit", {r_lat[7:0], 7'h0, r_hit}, {8'd0, 7'h0, 1'b1});
        access(16'h3892, 1'b0, 16'h0);
        check_val("mru_way1_hit", 32'(r_hit), 32'd1);

        // Miss with tag 0x0B evicts dirty way 0: write-back precedes the refill
        base = ev_addr.size();
        access(16'h5890, 1'b0, 16'h0);
        check_val("dirty_lat", r_lat, 11);
        check_val("dirty_data", {r_hit, r_data}, {1'b0, 16'hAC48});
        check_val("dirty_nev", ev_addr.size() - base, 8);
        check_val("wb0", {ev_wr[base], ev_addr[base], ev_data[base]}, {1'b1, 16'h1890, 16'h8C48});
        check_val("wb2", {ev_wr[base+2], ev_addr[base+2], ev_data[base+2]}, {1'b1, 16'h1894, 16'hBEEF});
        check_val("wb3", {ev_wr[base+3], ev_addr[base+3], ev_data[base+3]}, {1'b1, 16'h1896, 16'h8C4B});
        check_val("wb_then_rd", {ev_wr[base+4], ev_addr[base+4]}, {1'b0, 16'h5890});

        // MRU: A, B, C in set 0x34 -> A evicted, B still resident
        access(16'h09A0, 1'b0, 16'h0);
        access(16'h11A0, 1'b0, 16'h0);
        access(16'h21A0, 1'b0, 16'h0);
        check_val("mru_c_miss", 32'(r_hit), 32'd0);
        access(16'h11A0, 1'b0, 16'h0);
        check_val("mru_b_hit", {r_hit, r_data}, {1'b1, 16'h88D0});
        access(16'h09A0, 1'b0, 16'h0);
        check_val("mru_a_miss", {r_hit, r_data}, {1'b0, 16'h84D0});

        // m_stall held 3 cycles at the start of FILL
        base = ev_addr.size();
        @(negedge clk); addr = 16'h0AB0; read = 1'b1;
        @(negedge clk); m_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check_val("stall_hold", {fm_rd, fm_addr}, {1'b1, 16'h0AB0});
            @(negedge clk);
        end
        m_stall = 1'b0;
        wait_done();
        check_val("stall_lat", r_lat, 6);
        check_val("stall_data", {r_hit, r_data}, {1'b0, 16'h8558});
        check_val("stall_nrd", ev_addr.size() - base, 4);
        check_val("stall_rd1", ev_addr[base+1], 16'h0AB2);
        check_val("stall_rd3", ev_addr[base+3], 16'h0AB6);

        // Reset in the middle of FILL
        @(negedge clk); addr = 16'h13C0; read = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; read = 1'b0;
        #1 check_val("midrst_outs", {fm_rd, fm_wr, fs_stall, fc_enable}, 32'h0);
        @(negedge clk); rst = 1'b0;
        #1 check_val("postrst_outs", {fm_rd, fm_wr, fs_stall, fs_done, fc_enable, fc_write}, 32'h0);
        base = ev_addr.size(); fbase = fill_wr_cnt;
        repeat (6) @(negedge clk);
        check_val("postrst_quiet", {16'(ev_addr.size() - base), 16'(fill_wr_cnt - fbase)}, 32'h0);

        // read and write together
        base = ev_addr.size();
        @(negedge clk); addr = 16'h1892; read = 1'b1; write = 1'b1;
        #1 check_val("conflict", {fs_done, fs_err, fm_rd, fm_wr, fc_enable}, {1'b1, 1'b1, 4'h0});
        @(posedge clk); #1 read = 1'b0; write = 1'b0;
        @(negedge clk);
        check_val("conflict_nomem", ev_addr.size() - base, 0);

        // Memory error during a refill is reported with the completion only
        @(negedge clk); addr = 16'h0CD0; read = 1'b1;
        @(negedge clk); m_err = 1'b1;
        @(negedge clk); m_err = 1'b0;
        wait_done();
        check_val("err_done", {r_err, r_hit, r_data}, {1'b1, 1'b0, 16'h8668});
        access(16'h0CD0, 1'b0, 16'h0);
        check_val("err_cleared", {r_err, r_hit}, {1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
